// File: rtl/spi_link_pkg.sv
// Shared definitions for the multi-channel SPI frame link (master and slave sides).
package spi_link_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEAD,
    SHIFT,
    TRAIL,
    GAP
  } link_state_t;

  localparam int   HDR_W     = 16;
  localparam logic SSEL_IDLE = 1'b1;
  localparam logic SCK_IDLE  = 1'b0;

endpackage

// File: rtl/spi_tick_sync.sv
// Brings the slow sim_clk tick into the clk domain and emits a one-cycle rising-edge pulse.
module spi_tick_sync (
  input  logic clk,
  input  logic reset,
  input  logic tick_async,
  output logic tick_rise
);

  logic s1, s2, s3;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= tick_async;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign tick_rise = s2 & ~s3;

endmodule

// File: rtl/spi_frame_master_multi.sv
// Serialises N_CH snapshotted words (optionally led by a frame-counter header) into one SSEL frame per tick.
module spi_frame_master_multi
  import spi_link_pkg::*;
#(
  parameter int N_CH      = 2,
  parameter int W         = 32,
  parameter int SEND_HDR  = 1,
  parameter int LSB_FIRST = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic [23:0]         clkdiv,
  input  logic                sim_tick,
  input  logic [N_CH*W-1:0]   data_flat,
  output logic                SCK,
  output logic                DATA_OUT,
  output logic                SSEL,
  output logic                busy,
  output logic                frame_done,
  output logic [15:0]         frame_cnt,
  output logic [15:0]         overrun_cnt
);

  localparam int HDR_BITS = (SEND_HDR != 0) ? HDR_W : 0;
  localparam int NB       = N_CH * W + HDR_BITS;
  localparam int BCW      = $clog2(NB + 1);
  localparam logic [BCW-1:0] NB_CNT = BCW'(NB);

  logic              tick_rise;
  link_state_t       state;
  logic [23:0]       half_cnt;
  logic [23:0]       h_m1;
  logic [BCW-1:0]    bit_cnt;
  logic [NB-1:0]     shreg;
  logic [NB-1:0]     tx_vec;

  spi_tick_sync u_tick_sync (
    .clk        (clk),
    .reset      (reset),
    .tick_async (sim_tick),
    .tick_rise  (tick_rise)
  );

  // Frame laid out in transmission order: bit NB-1 goes on the wire first.
  always_comb begin
    tx_vec = '0;
    for (int i = 0; i < HDR_BITS; i++) begin
      tx_vec[NB-1-i] = (LSB_FIRST != 0) ? frame_cnt[i] : frame_cnt[HDR_W-1-i];
    end
    for (int k = 0; k < N_CH; k++) begin
      for (int i = 0; i < W; i++) begin
        tx_vec[NB-1-HDR_BITS-k*W-i] = (LSB_FIRST != 0) ? data_flat[k*W+i]
                                                       : data_flat[k*W+W-1-i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      SCK         <= SCK_IDLE;
      DATA_OUT    <= 1'b0;
      SSEL        <= SSEL_IDLE;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      frame_cnt   <= 16'd0;
      overrun_cnt <= 16'd0;
      half_cnt    <= 24'd0;
      h_m1        <= 24'd0;
      bit_cnt     <= '0;
      shreg       <= '0;
    end else begin
      frame_done <= 1'b0;
      if (tick_rise && (state != IDLE) && (overrun_cnt != 16'hFFFF)) begin
        overrun_cnt <= overrun_cnt + 16'd1;
      end
      case (state)
        IDLE: begin
          if (tick_rise && en) begin
            shreg     <= {tx_vec[NB-2:0], 1'b0};
            DATA_OUT  <= tx_vec[NB-1];
            h_m1      <= clkdiv;
            half_cnt  <= 24'd0;
            bit_cnt   <= '0;
            SSEL      <= ~SSEL_IDLE;
            busy      <= 1'b1;
            frame_cnt <= frame_cnt + 16'd1;
            state     <= LEAD;
          end
        end
        LEAD: begin
          if (half_cnt == h_m1) begin
            half_cnt <= 24'd0;
            SCK      <= ~SCK_IDLE;
            state    <= SHIFT;
          end else begin
            half_cnt <= half_cnt + 24'd1;
          end
        end
        SHIFT: begin
          if (half_cnt != h_m1) begin
            half_cnt <= half_cnt + 24'd1;
          end else begin
            half_cnt <= 24'd0;
            if (SCK) begin
              SCK      <= SCK_IDLE;
              DATA_OUT <= shreg[NB-1];
              shreg    <= {shreg[NB-2:0], 1'b0};
              bit_cnt  <= bit_cnt + 1'b1;
            end else if (bit_cnt == NB_CNT) begin
              DATA_OUT   <= 1'b0;
              SSEL       <= SSEL_IDLE;
              frame_done <= 1'b1;
              state      <= TRAIL;
            end else begin
              SCK <= ~SCK_IDLE;
            end
          end
        end
        TRAIL: begin
          half_cnt <= 24'd0;
          state    <= GAP;
        end
        GAP: begin
          if (half_cnt == h_m1) begin
            half_cnt <= 24'd0;
            busy     <= 1'b0;
            state    <= IDLE;
          end else begin
            half_cnt <= half_cnt + 24'd1;
          end
        end
        default: begin
          SCK   <= SCK_IDLE;
          SSEL  <= SSEL_IDLE;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_frame_master_multi.sv
// Directed bench: instance a is the two-word MSB-first build with header, instance b the one-word LSB-first build.
module tb_spi_frame_master_multi;

  logic        clk = 1'b0;
  logic        reset_a, reset_b, en_a, en_b, tick_a, tick_b;
  logic [23:0] clkdiv_a, clkdiv_b;
  logic [63:0] data_a;
  logic [31:0] data_b;
  logic        sck_a, dout_a, ssel_a, busy_a, done_a;
  logic        sck_b, dout_b, ssel_b, busy_b, done_b;
  logic [15:0] fc_a, oc_a, fc_b, oc_b;

  int num_checks = 0;
  int num_fail   = 0;

  logic [127:0] cap_a = '0, cap_b = '0;
  logic         sck_prev_a = 1'b0, sck_prev_b = 1'b0;
  int rises_a = 0, low_a = 0, dones_a = 0;
  int rises_b = 0, low_b = 0, dones_b = 0;
  int r0, l0, d0;

  localparam logic [79:0] FRAME_H0 = 80'h0000_3F666666_42A00000;
  localparam logic [79:0] FRAME_H1 = 80'h0001_3F666666_42A00000;

  always #5 clk = ~clk;

  spi_frame_master_multi #(.N_CH(2), .W(32), .SEND_HDR(1), .LSB_FIRST(0)) dut_a (
    .clk(clk), .reset(reset_a), .en(en_a), .clkdiv(clkdiv_a), .sim_tick(tick_a),
    .data_flat(data_a), .SCK(sck_a), .DATA_OUT(dout_a), .SSEL(ssel_a), .busy(busy_a),
    .frame_done(done_a), .frame_cnt(fc_a), .overrun_cnt(oc_a)
  );

  spi_frame_master_multi #(.N_CH(1), .W(32), .SEND_HDR(0), .LSB_FIRST(1)) dut_b (
    .clk(clk), .reset(reset_b), .en(en_b), .clkdiv(clkdiv_b), .sim_tick(tick_b),
    .data_flat(data_b), .SCK(sck_b), .DATA_OUT(dout_b), .SSEL(ssel_b), .busy(busy_b),
    .frame_done(done_b), .frame_cnt(fc_b), .overrun_cnt(oc_b)
  );

  // Wire-level observers: bit captured on each SCK rise, SSEL-low cycles and frame_done pulses tallied.
  always @(negedge clk) begin
    sck_prev_a <= sck_a;
    if (sck_a && !sck_prev_a) begin
      cap_a   <= {cap_a[126:0], dout_a};
      rises_a <= rises_a + 1;
    end
    if (!ssel_a) low_a <= low_a + 1;
    if (done_a) dones_a <= dones_a + 1;
  end

  always @(negedge clk) begin
    sck_prev_b <= sck_b;
    if (sck_b && !sck_prev_b) begin
      cap_b   <= {cap_b[126:0], dout_b};
      rises_b <= rises_b + 1;
    end
    if (!ssel_b) low_b <= low_b + 1;
    if (done_b) dones_b <= dones_b + 1;
  end

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    num_checks++;
    if (observed !== expected) begin
      num_fail++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input bit sel);
    if (sel) tick_b = 1'b1; else tick_a = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    if (sel) tick_b = 1'b0; else tick_a = 1'b0;
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic doReset(input bit sel);
    if (sel) reset_b = 1'b1; else reset_a = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    if (sel) reset_b = 1'b0; else reset_a = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic snapshot(input bit sel);
    r0 = sel ? rises_b : rises_a;
    l0 = sel ? low_b : low_a;
    d0 = sel ? dones_b : dones_a;
  endtask

  task automatic waitFrame(input bit sel, input int budget);
    int n = 0;
    int d_start = d0;
    while (((sel ? dones_b : dones_a) == d_start) && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    while ((sel ? busy_b : busy_a) && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("frame_complete", 128'(n < budget), 128'd1);
  endtask

  initial begin
    reset_a = 1'b1; reset_b = 1'b1; en_a = 1'b1; en_b = 1'b1;
    tick_a = 1'b0; tick_b = 1'b0;
    clkdiv_a = 24'd13; clkdiv_b = 24'd0;
    data_a = {32'h42A00000, 32'h3F666666};
    data_b = 32'h80000001;
    repeat (3) @(posedge clk);
    #1;
    reset_a = 1'b0; reset_b = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("reset_state_a", 128'({ssel_a, sck_a, busy_a, dout_a, done_a, fc_a, oc_a}),
                128'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000}));

    // Two-word frame with header; inputs scrambled once the frame is under way.
    snapshot(0);
    applyStimulus(0);
    data_a   = 64'hDEADBEEF_CAFEF00D;
    clkdiv_a = 24'd2;
    waitFrame(0, 4000);
    checkOutput("t1_rises", 128'(rises_a - r0), 128'd80);
    checkOutput("t1_ssel_low", 128'(low_a - l0), 128'd2254);
    checkOutput("t1_done_pulses", 128'(dones_a - d0), 128'd1);
    checkOutput("t1_bits", 128'(cap_a[79:0]), 128'(FRAME_H0));
    checkOutput("t1_frame_cnt", 128'(fc_a), 128'd1);

    // Second tick lands mid-frame and must only bump the overrun counter.
    doReset(0);
    clkdiv_a = 24'd1;
    data_a   = {32'h42A00000, 32'h3F666666};
    snapshot(0);
    applyStimulus(0);
    applyStimulus(0);
    waitFrame(0, 1000);
    checkOutput("t3_overrun", 128'(oc_a), 128'd1);
    checkOutput("t3_frame_cnt", 128'(fc_a), 128'd1);
    checkOutput("t3_bits", 128'(cap_a[79:0]), 128'(FRAME_H0));
    checkOutput("t3_rises", 128'(rises_a - r0), 128'd80);
    snapshot(0);
    applyStimulus(0);
    waitFrame(0, 1000);
    checkOutput("t3_frame_cnt2", 128'(fc_a), 128'd2);
    checkOutput("t3_bits_hdr1", 128'(cap_a[79:0]), 128'(FRAME_H1));

    // Abort a frame with reset around bit 20.
    snapshot(0);
    applyStimulus(0);
    for (int n = 0; n < 500 && (rises_a - r0) < 20; n++) begin
      @(posedge clk);
      #1;
    end
    checkOutput("t4_reached_bit20", 128'(rises_a - r0), 128'd20);
    reset_a = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("t4_abort_state", 128'({ssel_a, sck_a, busy_a, fc_a, oc_a}),
                128'({1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000}));
    repeat (2) @(posedge clk);
    #1;
    reset_a = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("t4_no_done", 128'(dones_a - d0), 128'd0);
    snapshot(0);
    applyStimulus(0);
    waitFrame(0, 1000);
    checkOutput("t4_bits_after_abort", 128'(cap_a[79:0]), 128'(FRAME_H0));
    checkOutput("t4_frame_cnt", 128'(fc_a), 128'd1);

    // Ticks ignored while disabled; disabling mid-frame lets the frame finish.
    en_a = 1'b0;
    applyStimulus(0);
    repeat (10) @(posedge clk);
    #1;
    checkOutput("t5_disabled", 128'({busy_a, ssel_a, fc_a, oc_a}),
                128'({1'b0, 1'b1, 16'h0001, 16'h0000}));
    en_a = 1'b1;
    snapshot(0);
    applyStimulus(0);
    en_a = 1'b0;
    waitFrame(0, 1000);
    en_a = 1'b1;
    checkOutput("t5_rises", 128'(rises_a - r0), 128'd80);
    checkOutput("t5_done_pulses", 128'(dones_a - d0), 128'd1);
    checkOutput("t5_frame_cnt", 128'(fc_a), 128'd2);

    // Single word at clkdiv 0, LSB first.
    snapshot(1);
    applyStimulus(1);
    waitFrame(1, 500);
    checkOutput("t2_rises", 128'(rises_b - r0), 128'd32);
    checkOutput("t2_ssel_low", 128'(low_b - l0), 128'd65);
    checkOutput("t2_bits", 128'(cap_b[31:0]), 128'h80000001);
    checkOutput("t2_frame_cnt", 128'(fc_b), 128'd1);

    data_b = 32'h00000001;
    snapshot(1);
    applyStimulus(1);
    waitFrame(1, 500);
    checkOutput("t6_lsb_bits", 128'(cap_b[31:0]), 128'h80000000);
    checkOutput("t6_first_bit", 128'(cap_b[31]), 128'd1);

    force dut_b.frame_cnt = 16'hFFFF;
    #2;
    release dut_b.frame_cnt;
    clkdiv_b = 24'd3;
    snapshot(1);
    applyStimulus(1);
    checkOutput("t6_frame_cnt_wrap", 128'(fc_b), 128'd0);
    force dut_b.overrun_cnt = 16'hFFFD;
    #2;
    release dut_b.overrun_cnt;
    applyStimulus(1);
    applyStimulus(1);
    applyStimulus(1);
    checkOutput("t6_overrun_sat", 128'(oc_b), 128'hFFFF);
    waitFrame(1, 1000);
    checkOutput("t6_rises", 128'(rises_b - r0), 128'd32);

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
